// File: rtl/swipt_fsk_tx.sv
// SWIPT transmit carrier generator: F0 preamble, binary FSK data bytes, F0 trailer.
// Optional build macro: TX_PARITY_EN appends an even-parity symbol after every byte.
module swipt_fsk_tx #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned F0           = 36000,
  parameter int unsigned DELF         = 12000,
  parameter int unsigned PREAMBLE_CYC = 64,
  parameter int unsigned SYM_CYC      = 16,
  parameter int unsigned TRAIL_CYC    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        link,
  output logic        freq_rdy,
  output logic [31:0] f,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] H0   = 32'(CLK_HZ / (2 * F0));
  localparam logic [31:0] H1   = 32'(CLK_HZ / (2 * (F0 + DELF)));
  localparam logic [31:0] HM   = 32'(CLK_HZ / (2 * (F0 - DELF)));
  localparam logic [31:0] F_MID = 32'(F0);
  localparam logic [31:0] F_HI  = 32'(F0 + DELF);
  localparam logic [31:0] F_LO  = 32'(F0 - DELF);
  localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_CYC - 1);
  localparam logic [15:0] SYM_LAST   = 16'(SYM_CYC - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(TRAIL_CYC - 1);
`ifdef TX_PARITY_EN
  localparam int unsigned NSYM = 9;
`else
  localparam int unsigned NSYM = 8;
`endif
  localparam logic [3:0] LAST_SYM = 4'(NSYM - 1);

  // Deviation must leave a positive low tone
  if (F0 <= DELF) begin : g_dev_check
    $error("swipt_fsk_tx: F0 must exceed DELF");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_TRAIL} state_t;

  state_t          state, state_n;
  logic [31:0]     hcnt, hcnt_n, hact, hact_n, f_n;
  logic [15:0]     cyc, cyc_n;
  logic [7:0]      remain, remain_n, buf_data, buf_data_n;
  logic            buf_full, buf_full_n;
  logic [NSYM-1:0] shreg, shreg_n, load_word;
  logic [3:0]      sym, sym_n;
  logic            link_n, busy_n, done_n, err_n, tx_ready_n, freq_rdy_n;
  logic            rise, load, accept;

`ifdef TX_PARITY_EN
  assign load_word = {^buf_data, buf_data};
`else
  assign load_word = buf_data;
`endif

  // Next-state, carrier and buffer logic
  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    hact_n     = hact;
    f_n        = f;
    cyc_n      = cyc;
    remain_n   = remain;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    shreg_n    = shreg;
    sym_n      = sym;
    link_n     = link;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    load       = 1'b0;
    accept     = tx_valid & tx_ready;
    rise       = (hcnt == 32'd0) && !link;
    if (!en) begin
      state_n    = S_IDLE;
      link_n     = 1'b0;
      hcnt_n     = H0 - 32'd1;
      hact_n     = H0;
      f_n        = F_MID;
      cyc_n      = 16'd0;
      buf_full_n = 1'b0;
      busy_n     = 1'b0;
      err_n      = busy;
    end else begin
      if (hcnt == 32'd0) begin
        link_n = !link;
        hcnt_n = hact - 32'd1;
      end else begin
        hcnt_n = hcnt - 32'd1;
      end
      if (accept) begin
        buf_full_n = 1'b1;
        buf_data_n = tx_data;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n  = S_PRE;
            busy_n   = 1'b1;
            remain_n = len;
            cyc_n    = 16'd0;
          end
        end
        S_PRE: begin
          if (rise) begin
            if (cyc == PRE_LAST) begin
              cyc_n = 16'd0;
              if (remain == 8'd0) begin
                state_n = S_TRAIL;
              end else if (buf_full) begin
                state_n = S_DATA;
                load    = 1'b1;
              end else begin
                err_n   = 1'b1;
                state_n = S_TRAIL;
              end
            end else begin
              cyc_n = cyc + 16'd1;
            end
          end
        end
        S_DATA: begin
          if (rise) begin
            if (cyc == SYM_LAST) begin
              cyc_n = 16'd0;
              if (sym != LAST_SYM) begin
                sym_n   = sym + 4'd1;
                shreg_n = shreg >> 1;
              end else if (remain == 8'd0) begin
                state_n = S_TRAIL;
              end else if (buf_full) begin
                load = 1'b1;
              end else begin
                err_n   = 1'b1;
                state_n = S_TRAIL;
              end
            end else begin
              cyc_n = cyc + 16'd1;
            end
          end
        end
        default: begin
          if (rise) begin
            if (cyc == TRAIL_LAST) begin
              cyc_n   = 16'd0;
              state_n = S_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              cyc_n = cyc + 16'd1;
            end
          end
        end
      endcase
      if (load) begin
        shreg_n    = load_word;
        sym_n      = 4'd0;
        remain_n   = remain - 8'd1;
        buf_full_n = accept;
      end
      // Tone only changes on a rising carrier edge so the phase stays continuous
      if (rise) begin
        if (state_n == S_DATA) begin
          hact_n = shreg_n[0] ? H1 : HM;
          f_n    = shreg_n[0] ? F_HI : F_LO;
        end else begin
          hact_n = H0;
          f_n    = F_MID;
        end
        hcnt_n = hact_n - 32'd1;
      end
    end
    freq_rdy_n = (state_n != S_DATA);
    tx_ready_n = en && ((state_n == S_PRE) || (state_n == S_DATA)) &&
                 !buf_full_n && (remain_n != 8'd0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hcnt     <= H0 - 32'd1;
      hact     <= H0;
      f        <= F_MID;
      cyc      <= 16'd0;
      remain   <= 8'd0;
      buf_data <= 8'd0;
      buf_full <= 1'b0;
      shreg    <= '0;
      sym      <= 4'd0;
      link     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_ready <= 1'b0;
      freq_rdy <= 1'b1;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      hact     <= hact_n;
      f        <= f_n;
      cyc      <= cyc_n;
      remain   <= remain_n;
      buf_data <= buf_data_n;
      buf_full <= buf_full_n;
      shreg    <= shreg_n;
      sym      <= sym_n;
      link     <= link_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      tx_ready <= tx_ready_n;
      freq_rdy <= freq_rdy_n;
    end
  end

endmodule
